// File: rtl/dmem_port.sv
// dmem_port: MEM-stage data-memory responder for the kanade32 pipeline.
// Accepts a load/store request, stalls the pipeline through busy for a fixed
// latency, then commits to an internal byte-lane word RAM and pulses done
// with the extended load data.
//
// Parameters:
//   ADDR_W  - RAM depth is 2**ADDR_W 32-bit words; higher address bits wrap.
//   LATENCY - wait cycles per access (1..15).
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   req_read, req_write - level requests (write wins when both are high)
//   acc_mode            - 0 word, 1 half signed, 2 half unsigned,
//                         3 byte signed, 4 byte unsigned, 5..7 word
//   addr, wdata         - byte address and store data
//   rdata               - extended load data, held until the next done
//   busy                - stall request to the pipeline
//   done                - one-cycle completion pulse
//   fault               - misaligned-access flag, valid with done
//
// Build option: define DMEM_MISALIGN_FAULT_EN to flag misaligned accesses
// (no RAM write, rdata = 0, fault = 1). Without it, low address bits below
// the access size are forced to zero and fault stays 0.

module dmem_port #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t state, state_next;
  logic [3:0] cnt;
  logic       accept;
  logic       commit;

  // Latched request
  logic              is_write_q;
  logic [2:0]        mode_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;

  // Access decode
  logic              size_b;
  logic              size_h;
  logic              misaligned;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        be;
  logic [31:0]       wd_lanes;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        busy = req_read | req_write;
        if (req_read | req_write) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      is_write_q <= req_write;
      mode_q     <= acc_mode;
      addr_q     <= addr[ADDR_W+1:0];
      wdata_q    <= wdata;
    end
  end

  // ------------------------------------------------------- access decode
  always_comb begin
    size_b = (mode_q == 3'd3) || (mode_q == 3'd4);
    size_h = (mode_q == 3'd1) || (mode_q == 3'd2);
`ifdef DMEM_MISALIGN_FAULT_EN
    misaligned = (size_h && addr_q[0]) ||
                 (!size_b && !size_h && (addr_q[1:0] != 2'b00));
    lane       = addr_q[1:0];
`else
    misaligned = 1'b0;
    lane       = size_b ? addr_q[1:0] :
                 size_h ? {addr_q[1], 1'b0} : 2'b00;
`endif
    word_idx = addr_q[ADDR_W+1:2];

    if (size_b) begin
      be       = 4'b0001 << lane;
      wd_lanes = {4{wdata_q[7:0]}};
    end else if (size_h) begin
      be       = lane[1] ? 4'b1100 : 4'b0011;
      wd_lanes = {2{wdata_q[15:0]}};
    end else begin
      be       = 4'b1111;
      wd_lanes = wdata_q;
    end

    rd_word = mem[word_idx];
    shifted = rd_word >> {lane, 3'b000};
    case (mode_q)
      3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    load_ext = {16'h0000, shifted[15:0]};
      3'd3:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd4:    load_ext = {24'h000000, shifted[7:0]};
      default: load_ext = rd_word;
    endcase
  end

  // ----------------------------------------------------------------- RAM
  // Reset on the commit edge still wins, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (commit && !reset && is_write_q && !misaligned) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[word_idx][i*8 +: 8] <= wd_lanes[i*8 +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------ response
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
      fault <= 1'b0;
    end else if (commit) begin
      rdata <= (is_write_q || misaligned) ? '0 : load_ext;
      fault <= misaligned;
    end else if (state == RESP) begin
      fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  acc_mode = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        fault;

  always #5 clk = ~clk;

  dmem_port #(.ADDR_W(12), .LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .req_read(req_read),
    .req_write(req_write),
    .acc_mode(acc_mode),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy),
    .done(done),
    .fault(fault)
  );

  typedef struct {
    bit          chk;
    bit          busy;
    bit          done;
    bit          fault;
    logic [31:0] rdata;
    bit          lit_en;
    logic [31:0] lit;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          running = 1'b1;
  logic [31:0] held = '0;
  byte unsigned mem_m [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Single compare process: one expectation per clock cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        if (e.chk) begin
          check("busy", {31'b0, busy}, {31'b0, e.busy});
          check("done", {31'b0, done}, {31'b0, e.done});
          check("fault", {31'b0, fault}, {31'b0, e.fault});
          check("rdata", rdata, e.rdata);
          if (e.lit_en) check("rdata_literal", rdata, e.lit);
        end
      end else if (running) begin
        n_checks++;
        $display("FAIL expect_queue at %0t: got empty, expected an entry", $time);
      end
    end
  end

  function automatic void push(input bit chk, input bit b, input bit d, input bit f,
                               input logic [31:0] rd, input bit le, input logic [31:0] lit);
    exp_t e;
    e.chk = chk; e.busy = b; e.done = d; e.fault = f;
    e.rdata = rd; e.lit_en = le; e.lit = lit;
    expq.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte-addressed reference memory over the low 256 bytes.
  function automatic void model(input bit wr, input logic [2:0] mode, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] r, output bit f);
    int n;
    int off;
    logic [31:0] v;
    n = (mode == 3'd1 || mode == 3'd2) ? 2 : (mode == 3'd3 || mode == 3'd4) ? 1 : 4;
    off = int'(a[7:0]);
    f = 1'b0;
    r = '0;
    if (off % n != 0) begin
`ifdef DMEM_MISALIGN_FAULT_EN
      f = 1'b1;
      return;
`else
      off = off - (off % n);
`endif
    end
    if (wr) begin
      for (int i = 0; i < n; i++) mem_m[off + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[off + i]) << (8 * i));
      if (mode == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      if (mode == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
      r = v;
    end
  endfunction

  task automatic do_access(input bit rd, input bit wr, input logic [2:0] mode,
                           input logic [31:0] a, input logic [31:0] wd, input bit hold,
                           input bit le, input logic [31:0] lit);
    logic [31:0] r;
    bit f;
    model(wr, mode, a, wd, r, f);
    tick();
    req_read = rd; req_write = wr; acc_mode = mode; addr = a; wdata = wd;
    push(1, 1, 0, 0, held, 0, '0);
    for (int c = 1; c <= int'(LAT); c++) begin
      tick();
      addr = $urandom; wdata = $urandom; acc_mode = 3'($urandom);
      push(1, 1, 0, 0, held, 0, '0);
    end
    tick();
    if (!hold) begin
      req_read = 1'b0; req_write = 1'b0;
    end
    held = r;
    push(1, 0, 1, f, r, le, lit);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      req_read = 1'b0; req_write = 1'b0;
      push(1, 0, 0, 0, held, 0, '0);
    end
  endtask

  task automatic st(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] wd);
    do_access(0, 1, mode, a, wd, 0, 1, 32'h0);
  endtask

  task automatic ld(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] lit);
    do_access(1, 0, mode, a, 32'h0, 0, 1, lit);
  endtask

  initial begin
    logic [31:0] mis_lit;
    int kind;
    bit hold;

    // Reset
    tick(); push(0, 0, 0, 0, '0, 0, '0);
    tick(); reset = 1'b0; push(1, 0, 0, 0, '0, 0, '0);
    idle(1);

    // Fill the test region so every later load reads known data.
    for (int w = 0; w < 64; w++) st(3'd0, 32'(w * 4), (w == 16) ? 32'h0 : $urandom);

    // Directed cases with hand-computed results
    st(3'd0, 32'h10, 32'hDEAD_BEEF);
    idle(1);
    ld(3'd0, 32'h10, 32'hDEAD_BEEF);
    st(3'd0, 32'h20, 32'h1234_5680);
    ld(3'd3, 32'h20, 32'hFFFF_FF80);
    ld(3'd4, 32'h20, 32'h0000_0080);
    ld(3'd4, 32'h23, 32'h0000_0012);
    st(3'd2, 32'h22, 32'hFFFF_A5A5);
    ld(3'd0, 32'h20, 32'hA5A5_5680);
    ld(3'd1, 32'h22, 32'hFFFF_A5A5);
    ld(3'd2, 32'h22, 32'h0000_A5A5);

    // Misaligned word store
    st(3'd0, 32'h30, 32'h0102_0304);
    st(3'd0, 32'h31, 32'hCAFE_F00D);
`ifdef DMEM_MISALIGN_FAULT_EN
    mis_lit = 32'h0102_0304;
`else
    mis_lit = 32'hCAFE_F00D;
`endif
    ld(3'd0, 32'h30, mis_lit);

    // Back-to-back loads with req_read held through completion
    do_access(1, 0, 3'd0, 32'h10, 32'h0, 1, 1, 32'hDEAD_BEEF);
    do_access(1, 0, 3'd0, 32'h20, 32'h0, 1, 1, 32'hA5A5_5680);
    // Both strobes high: a store, rdata 0
    do_access(1, 1, 3'd0, 32'h50, 32'h5555_AAAA, 0, 1, 32'h0);
    ld(3'd0, 32'h50, 32'h5555_AAAA);

    // Reset during WAIT of a store aborts it
    tick();
    req_write = 1'b1; req_read = 1'b0; acc_mode = 3'd0; addr = 32'h40; wdata = 32'h1111_1111;
    push(1, 1, 0, 0, held, 0, '0);
    tick(); reset = 1'b1; push(1, 1, 0, 0, held, 0, '0);
    tick(); reset = 1'b0; req_write = 1'b0; held = '0; push(1, 0, 0, 0, '0, 1, 32'h0);
    idle(1);
    ld(3'd0, 32'h40, 32'h0);

    // Randomized traffic with wrapping upper address bits
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 2);
      hold = 1'($urandom_range(0, 1));
      do_access(kind != 1, kind != 0, 3'($urandom_range(0, 7)),
                $urandom & 32'hFFFF_C0FF, $urandom, hold, 0, '0);
      if (!hold) idle($urandom_range(0, 2));
    end

    idle(3);
    running = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
